bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares the two ports of one BRAMLikeMem1 instance between NREQ requesters.
//  Grants up to two requests per cycle with round-robin fairness and resolves same-address hazards.
//  Routes registered read data back to the originating requester.
//  Sits between requester engines and the memory's io_*_1 / io_*_2 port pins.
// PARAMETERS
//  NREQ  4   number of requesters (2..16)
//  DATA  36  data width; matches memory DATA
//  ADDR  16  address width; matches memory ADDR
// PORTS
//  clock            in   1          single clock; all state on rising edge
//  reset_n          in   1          asynchronous, active-low reset
//  io_req_valid     in   NREQ       request present, one bit per requester
//  io_req_write     in   NREQ       1=write, 0=read
//  io_req_addr      in   NREQ*ADDR  flattened; requester i at [i*ADDR +: ADDR]
//  io_req_data      in   NREQ*DATA  write data, flattened like addr
//  io_req_ready     out  NREQ       request accepted this cycle
//  io_rsp_valid     out  NREQ       read data valid for requester i
//  io_rsp_data      out  DATA       read data; qualified by io_rsp_valid
//  io_mem_enable_1/_2   out 1       to memory io_enable_1/_2
//  io_mem_write_1/_2    out 1       to memory io_write_1/_2
//  io_mem_addr_1/_2     out ADDR    to memory io_addr_1/_2
//  io_mem_dataIn_1/_2   out DATA    to memory io_dataIn_1/_2
//  io_mem_dataOut_1/_2  in  DATA    from memory io_dataOut_1/_2 (1-cycle registered)
// BEHAVIOUR
//  - Handshake: transfer on valid&ready. ready is combinational from valid/addr/write and the pointer.
//    valid must not depend on ready. Once raised, valid/addr/data/write are held until ready.
//  - Grant: scan from rr pointer P upward (mod NREQ).
//    First valid requester -> port 1. Next valid non-conflicting requester -> port 2.
//  - Conflict: candidate has the same addr as the port-1 grantee and either access is a write.
//    A conflicting candidate is skipped that cycle. The scan continues for another port-2 candidate.
//  - Pointer update: if any candidate was skipped, P <= first skipped index. Otherwise P <= last granted index+1.
//    No grant: P unchanged. This rule guarantees no starvation.
//  - Memory drive: enable_k=1 only on a grant; write_k=grantee write; addr/dataIn from grantee.
//    With no grant, addr/data are 0.
//  - Read latency: exactly 1 cycle.
//    A read accepted in cycle T asserts io_rsp_valid[i] in T+1, with io_rsp_data = the dataOut of its port.
//  - Response tag regs: valid bit + requester index per port.
//  - Two reads in one cycle respond to different requesters in the same T+1 cycle.
//    io_rsp_data is then ambiguous, so a second-port read is granted only if no port-1 read was granted.
//    Consequence: at most one read grant per cycle; write+read and write+write pairs are allowed.
//  - Writes produce no response; they complete at acceptance.
//  - Reset (async assert, sync deassert by the system): P=0, tag valids=0.
//    io_rsp_valid=0, io_req_ready=0, all io_mem_enable=0 while reset_n=0.
//  - Reset mid-read: the in-flight response is dropped; the requester reissues after reset.
// CONFIGURATION
//  BRAM_ARB_STATS_EN defined:
//    adds io_stat_grants [31:0] out: total accepted requests.
//    adds io_stat_conflicts [31:0] out: cycles with >=1 hazard skip.
//    Both counters saturate at 32'hFFFFFFFF and reset to 0.
//  BRAM_ARB_STATS_EN undefined: counters and ports are absent; the block is otherwise identical.
// STRUCTURE
//  bram_arb_pkg:
//    REQ_W = $clog2(NREQ) helper
//    typedef rsp_tag_t {logic vld; logic [REQ_W-1:0] idx;}
//    constant STAT_W=32
//  Sub-module bram_arb_rr_pick:
//    combinational; inputs: request mask, pointer; output: one-hot first set bit at/after the pointer.
//    Instantiated twice (port 1 pick; port 2 pick on a masked vector).
// TESTING
//  1 Single reader: req0 read addr 5 (preloaded 0xABC) -> ready0 in T, rsp_valid[0]=1 data 0xABC in T+1.
//  2 All 4 valid, all writes, distinct addrs, P=0 -> T: grants 0,1; T+1: grants 2,3; P returns to 0.
//  3 Hazard: req0 write addr 7=0x11, req1 read addr 7 -> T: only req0; T+1: req1; rsp data 0x11 in T+2.
//  4 Two reads, distinct addrs -> one read per cycle, rsp_valid one-hot, each carries its own data.
//  5 reset_n low in cycle after a read grant -> rsp_valid stays 0, mem enables 0, P=0 after release.
//  6 With BRAM_ARB_STATS_EN: run scenario 3 -> io_stat_grants=2, io_stat_conflicts=1.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// ----------------------------------------------------------------------------
// bram_arb_pkg
// Shared types and constants for the BRAM port arbiter.
//   NREQ_MAX  largest supported requester count
//   STAT_W    width of the optional statistics counters
//   req_w()   index width for a given requester count ($clog2, minimum 1)
//   REQ_W     index width at NREQ_MAX, so response tags fit any legal NREQ
//   rsp_tag_t per-port response tag: valid bit + originating requester index
// ----------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int NREQ_MAX = 16;
  localparam int STAT_W   = 32;

  function automatic int req_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int REQ_W = req_w(NREQ_MAX);

  typedef struct packed {
    logic             vld;
    logic [REQ_W-1:0] idx;
  } rsp_tag_t;

endpackage

// File: rtl/bram_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// bram_arb_rr_pick
// Combinational round-robin picker: returns the first set bit of mask found
// scanning upward from ptr (wrapping modulo N), as a one-hot vector.
//   mask [N-1:0]   candidate bits
//   ptr  [PW-1:0]  scan start index (must be < N)
//   pick [N-1:0]   one-hot winner, all-zero when mask is empty
// ----------------------------------------------------------------------------
module bram_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic found;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it holding its old value and no latch is inferred.
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && mask[(int'(ptr) + k) % N]) begin
        pick[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// bram_port_arbiter
// Shares the two ports of one dual-port BRAM between NREQ requesters. Up to
// two requests are granted per cycle with round-robin fairness; a candidate
// hitting the port-1 grantee's address where either side writes is skipped.
// At most one read is granted per cycle so the single response bus is never
// ambiguous. Read data returns one cycle after acceptance, tagged back to
// the requester that issued it.
//
// Ports
//   clock, reset_n                  clock, asynchronous active-low reset
//   io_req_valid/write [NREQ]       per-requester request and direction
//   io_req_addr  [NREQ*ADDR]        requester i at [i*ADDR +: ADDR]
//   io_req_data  [NREQ*DATA]        requester i at [i*DATA +: DATA]
//   io_req_ready [NREQ]             request accepted this cycle
//   io_rsp_valid [NREQ], io_rsp_data read response, one cycle after accept
//   io_mem_*_1 / io_mem_*_2         memory port pins (dataOut registered)
//
// Optional feature: define BRAM_ARB_STATS_EN to add io_stat_grants (accepted
// requests) and io_stat_conflicts (cycles with an address-hazard skip), both
// saturating 32-bit counters.
// ----------------------------------------------------------------------------
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATA = 36,
  parameter int ADDR = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      io_req_valid,
  input  logic [NREQ-1:0]      io_req_write,
  input  logic [NREQ*ADDR-1:0] io_req_addr,
  input  logic [NREQ*DATA-1:0] io_req_data,
  output logic [NREQ-1:0]      io_req_ready,
  output logic [NREQ-1:0]      io_rsp_valid,
  output logic [DATA-1:0]      io_rsp_data,
`ifdef BRAM_ARB_STATS_EN
  output logic [STAT_W-1:0]    io_stat_grants,
  output logic [STAT_W-1:0]    io_stat_conflicts,
`endif
  output logic                 io_mem_enable_1,
  output logic                 io_mem_write_1,
  output logic [ADDR-1:0]      io_mem_addr_1,
  output logic [DATA-1:0]      io_mem_dataIn_1,
  input  logic [DATA-1:0]      io_mem_dataOut_1,
  output logic                 io_mem_enable_2,
  output logic                 io_mem_write_2,
  output logic [ADDR-1:0]      io_mem_addr_2,
  output logic [DATA-1:0]      io_mem_dataIn_2,
  input  logic [DATA-1:0]      io_mem_dataOut_2
);

  localparam int PW = req_w(NREQ);

  function automatic logic [PW-1:0] oh_idx(input logic [NREQ-1:0] oh);
    oh_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) oh_idx = PW'(i);
    end
  endfunction

  function automatic int slot(input logic [PW-1:0] p, input int k);
    return (int'(p) + k) % NREQ;
  endfunction

  logic [ADDR-1:0] req_addr [NREQ];
  logic [DATA-1:0] req_data [NREQ];
  logic [NREQ-1:0] live;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0] g1_oh, g2_oh, elig2, hazard_vec, block_vec;
  logic            g1_any, g2_any, skip_any, seen2;
  logic [PW-1:0]   i1, i2, skip_idx;
  rsp_tag_t        tag1, tag2;
`ifdef BRAM_ARB_STATS_EN
  logic            hazard_skip;
  logic [STAT_W:0] grant_sum;
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = io_req_addr[i*ADDR +: ADDR];
      req_data[i] = io_req_data[i*DATA +: DATA];
    end
  end

  // Gating valid with reset_n forces ready and memory enables low for the
  // whole reset window, not just from the first clock edge.
  assign live = io_req_valid & {NREQ{reset_n}};

  // Port 1: first valid requester at/after the pointer.
  bram_arb_rr_pick #(.N(NREQ), .PW(PW)) u_pick1 (
    .mask (live),
    .ptr  (ptr),
    .pick (g1_oh)
  );

  assign g1_any = |live;
  assign i1     = oh_idx(g1_oh);

  // A candidate is blocked for port 2 on an address hazard with the port-1
  // grantee, or when both would be reads (only one response bus exists).
  always_comb begin
    hazard_vec = '0;
    block_vec  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (live[j] && !g1_oh[j]) begin
        hazard_vec[j] = (req_addr[j] == req_addr[i1]) &&
                        (io_req_write[j] || io_req_write[i1]);
        block_vec[j]  = hazard_vec[j] || (!io_req_write[j] && !io_req_write[i1]);
      end
    end
  end

  assign elig2 = live & ~g1_oh & ~block_vec;

  bram_arb_rr_pick #(.N(NREQ), .PW(PW)) u_pick2 (
    .mask (elig2),
    .ptr  (ptr),
    .pick (g2_oh)
  );

  assign g2_any = |elig2;
  assign i2     = oh_idx(g2_oh);

  // Only blocked candidates the scan passed over before finding the port-2
  // grantee count as skipped; the pointer returns to the first of them so a
  // repeatedly blocked requester becomes the next port-1 winner.
  always_comb begin
    skip_any = 1'b0;
    skip_idx = '0;
    seen2    = 1'b0;
`ifdef BRAM_ARB_STATS_EN
    hazard_skip = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (g2_oh[slot(ptr, k)]) begin
        seen2 = 1'b1;
      end else if (!seen2 && block_vec[slot(ptr, k)]) begin
        if (!skip_any) skip_idx = PW'(slot(ptr, k));
        skip_any = 1'b1;
`ifdef BRAM_ARB_STATS_EN
        hazard_skip = hazard_skip | hazard_vec[slot(ptr, k)];
`endif
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (skip_any)    ptr_nxt = skip_idx;
    else if (g2_any) ptr_nxt = PW'(slot(i2, 1));
    else if (g1_any) ptr_nxt = PW'(slot(i1, 1));
  end

  assign io_req_ready = g1_oh | g2_oh;

  assign io_mem_enable_1 = g1_any;
  assign io_mem_write_1  = g1_any & io_req_write[i1];
  assign io_mem_addr_1   = g1_any ? req_addr[i1] : '0;
  assign io_mem_dataIn_1 = g1_any ? req_data[i1] : '0;
  assign io_mem_enable_2 = g2_any;
  assign io_mem_write_2  = g2_any & io_req_write[i2];
  assign io_mem_addr_2   = g2_any ? req_addr[i2] : '0;
  assign io_mem_dataIn_2 = g2_any ? req_data[i2] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr  <= '0;
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      ptr      <= ptr_nxt;
      tag1.vld <= g1_any && !io_req_write[i1];
      tag1.idx <= REQ_W'(i1);
      tag2.vld <= g2_any && !io_req_write[i2];
      tag2.idx <= REQ_W'(i2);
    end
  end

  // At most one tag is valid, so the data mux needs no priority concerns.
  always_comb begin
    io_rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      io_rsp_valid[i] = (tag1.vld && (tag1.idx == REQ_W'(i))) ||
                        (tag2.vld && (tag2.idx == REQ_W'(i)));
    end
    io_rsp_data = tag1.vld ? io_mem_dataOut_1 :
                  tag2.vld ? io_mem_dataOut_2 : '0;
  end

`ifdef BRAM_ARB_STATS_EN
  assign grant_sum = {1'b0, io_stat_grants} + {{STAT_W{1'b0}}, g1_any}
                                            + {{STAT_W{1'b0}}, g2_any};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_stat_grants    <= '0;
      io_stat_conflicts <= '0;
    end else begin
      io_stat_grants <= grant_sum[STAT_W] ? '1 : grant_sum[STAT_W-1:0];
      if (hazard_skip && (io_stat_conflicts != '1))
        io_stat_conflicts <= io_stat_conflicts + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed scenarios followed by randomized traffic for bram_port_arbiter,
// checked against a request-level reference model (scan order, hazard rule,
// pointer rule, shadow memory, one-cycle read response). Includes a simple
// dual-port memory with registered read data to close the loop.
// ----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int NREQ  = 4;
  localparam int DATA  = 36;
  localparam int ADDR  = 16;
  localparam int NPOOL = 8;

  logic clock = 1'b0;
  logic reset_n;

  logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_data;
  logic [DATA-1:0]      rsp_data;
  logic                 mem_en1, mem_wr1, mem_en2, mem_wr2;
  logic [ADDR-1:0]      mem_a1, mem_a2;
  logic [DATA-1:0]      mem_din1, mem_din2, mem_dout1, mem_dout2;
`ifdef BRAM_ARB_STATS_EN
  logic [31:0]          stat_grants, stat_conflicts;
`endif

  bram_port_arbiter #(.NREQ(NREQ), .DATA(DATA), .ADDR(ADDR)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .io_req_valid     (req_valid),
    .io_req_write     (req_write),
    .io_req_addr      (req_addr),
    .io_req_data      (req_data),
    .io_req_ready     (req_ready),
    .io_rsp_valid     (rsp_valid),
    .io_rsp_data      (rsp_data),
`ifdef BRAM_ARB_STATS_EN
    .io_stat_grants   (stat_grants),
    .io_stat_conflicts(stat_conflicts),
`endif
    .io_mem_enable_1  (mem_en1),
    .io_mem_write_1   (mem_wr1),
    .io_mem_addr_1    (mem_a1),
    .io_mem_dataIn_1  (mem_din1),
    .io_mem_dataOut_1 (mem_dout1),
    .io_mem_enable_2  (mem_en2),
    .io_mem_write_2   (mem_wr2),
    .io_mem_addr_2    (mem_a2),
    .io_mem_dataIn_2  (mem_din2),
    .io_mem_dataOut_2 (mem_dout2)
  );

  initial forever #5 clock = ~clock;

  // Dual-port memory, read-first, one-cycle registered read data.
  logic [DATA-1:0] tb_mem [0:(1<<ADDR)-1];
  always @(posedge clock) begin
    if (mem_en1) begin
      mem_dout1 <= tb_mem[mem_a1];
      if (mem_wr1) tb_mem[mem_a1] <= mem_din1;
    end
    if (mem_en2) begin
      mem_dout2 <= tb_mem[mem_a2];
      if (mem_wr2) tb_mem[mem_a2] <= mem_din2;
    end
  end

  // Reference model state.
  int              n_checks = 0;
  int              n_fail   = 0;
  int              m_ptr;
  logic [DATA-1:0] ref_mem [logic [ADDR-1:0]];
  logic [NREQ-1:0] exp_rsp_valid;
  logic [DATA-1:0] exp_rsp_data;
  longint unsigned m_grants, m_conflicts;
  logic [ADDR-1:0] pool [NPOOL];
  logic [DATA-1:0] pre7;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [ADDR-1:0] a,
                         input logic [DATA-1:0] d);
    req_valid[i]             = 1'b1;
    req_write[i]             = wr;
    req_addr[i*ADDR +: ADDR] = a;
    req_data[i*DATA +: DATA] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic model_reset();
    m_ptr         = 0;
    exp_rsp_valid = '0;
    exp_rsp_data  = '0;
    m_grants      = 0;
    m_conflicts   = 0;
  endtask

  // Walk requesters in round-robin order from the model pointer.
  function automatic void model_eval(output int g1, output int g2, output int fs,
                                     output bit hz);
    logic [ADDR-1:0] a_i, a_1;
    bit done;
    g1 = -1; g2 = -1; fs = -1; hz = 1'b0; done = 1'b0; a_1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      bit same, two_reads;
      i   = (m_ptr + k) % NREQ;
      a_i = req_addr[i*ADDR +: ADDR];
      if (!done && req_valid[i]) begin
        if (g1 < 0) begin
          g1  = i;
          a_1 = a_i;
        end else begin
          same      = (a_i == a_1) && (req_write[i] || req_write[g1]);
          two_reads = !req_write[i] && !req_write[g1];
          if (same || two_reads) begin
            if (fs < 0) fs = i;
            if (same) hz = 1'b1;
          end else begin
            g2   = i;
            done = 1'b1;
          end
        end
      end
    end
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, then
  // drop accepted requests just after the rising edge.
  task automatic step(input logic [NREQ-1:0] want, input bit chk_want);
    int g1, g2, fs;
    bit hz;
    logic [NREQ-1:0] er, nv;
    logic [DATA-1:0] nd, ed1, ed2;
    logic [ADDR-1:0] ea1, ea2;
    bit ew1, ew2;
    @(negedge clock);
    model_eval(g1, g2, fs, hz);
    er = '0;
    if (g1 >= 0) er[g1] = 1'b1;
    if (g2 >= 0) er[g2] = 1'b1;
    ew1 = (g1 >= 0) ? req_write[g1] : 1'b0;
    ea1 = (g1 >= 0) ? req_addr[g1*ADDR +: ADDR] : '0;
    ed1 = (g1 >= 0) ? req_data[g1*DATA +: DATA] : '0;
    ew2 = (g2 >= 0) ? req_write[g2] : 1'b0;
    ea2 = (g2 >= 0) ? req_addr[g2*ADDR +: ADDR] : '0;
    ed2 = (g2 >= 0) ? req_data[g2*DATA +: DATA] : '0;
    check("ready", 64'(req_ready), 64'(er));
    if (chk_want) check("dir_ready", 64'(req_ready), 64'(want));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
    check("rsp_data", 64'(rsp_data), 64'(exp_rsp_data));
    check("en1", 64'(mem_en1), 64'(g1 >= 0));
    check("wr1", 64'(mem_wr1), 64'(ew1));
    check("addr1", 64'(mem_a1), 64'(ea1));
    check("din1", 64'(mem_din1), 64'(ed1));
    check("en2", 64'(mem_en2), 64'(g2 >= 0));
    check("wr2", 64'(mem_wr2), 64'(ew2));
    check("addr2", 64'(mem_a2), 64'(ea2));
    check("din2", 64'(mem_din2), 64'(ed2));
`ifdef BRAM_ARB_STATS_EN
    check("stat_grants", 64'(stat_grants), m_grants);
    check("stat_conflicts", 64'(stat_conflicts), m_conflicts);
`endif
    nv = '0;
    nd = '0;
    if (g1 >= 0 && !ew1) begin nv[g1] = 1'b1; nd = ref_mem[ea1]; end
    if (g2 >= 0 && !ew2) begin nv[g2] = 1'b1; nd = ref_mem[ea2]; end
    if (g1 >= 0 && ew1) ref_mem[ea1] = ed1;
    if (g2 >= 0 && ew2) ref_mem[ea2] = ed2;
    m_grants    += longint'(g1 >= 0) + longint'(g2 >= 0);
    m_conflicts += longint'(hz);
    if (fs >= 0)      m_ptr = fs;
    else if (g2 >= 0) m_ptr = (g2 + 1) % NREQ;
    else if (g1 >= 0) m_ptr = (g1 + 1) % NREQ;
    @(posedge clock);
    #1;
    exp_rsp_valid = nv;
    exp_rsp_data  = nd;
    for (int i = 0; i < NREQ; i++) if (er[i]) req_valid[i] = 1'b0;
  endtask

  initial begin
    pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
             16'h0005, 16'h0007, 16'h8001, 16'hFFFF};
    reset_n = 1'b1;
    clear_reqs();
    model_reset();
    #1 reset_n = 1'b0;

    // Reset: a pending request must not be accepted.
    set_req(0, 1'b0, 16'd5, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_en1", 64'(mem_en1), 64'(0));
    check("rst_en2", 64'(mem_en2), 64'(0));
    @(posedge clock);
    #1;
    clear_reqs();
    reset_n = 1'b1;

    // Preload every pool address through requester 0.
    for (int p = 0; p < NPOOL; p++) begin
      logic [DATA-1:0] d;
      d = (pool[p] == 16'd5) ? DATA'(36'hABC) : DATA'({$urandom(), $urandom()});
      if (pool[p] == 16'd7) pre7 = d;
      set_req(0, 1'b1, pool[p], d);
      step(4'b0001, 1'b1);
    end

    // Single reader.
    set_req(0, 1'b0, 16'd5, '0);
    step(4'b0001, 1'b1);
    check("s1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("s1_rsp_data", 64'(rsp_data), 64'(36'hABC));

    // Lone grant to requester 3 wraps the pointer back to 0.
    set_req(3, 1'b1, 16'h8001, DATA'(36'h123456789));
    step(4'b1000, 1'b1);

    // Four writes, distinct addresses: pairs 0,1 then 2,3.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, pool[i], DATA'(36'h100 + i));
    step(4'b0011, 1'b1);
    step(4'b1100, 1'b1);

    // Two reads, distinct addresses: one per cycle.
    set_req(0, 1'b0, 16'd5, '0);
    set_req(1, 1'b0, 16'd7, '0);
    step(4'b0001, 1'b1);
    check("s4_rsp_valid_a", 64'(rsp_valid), 64'(4'b0001));
    check("s4_rsp_data_a", 64'(rsp_data), 64'(36'hABC));
    step(4'b0010, 1'b1);
    check("s4_rsp_valid_b", 64'(rsp_valid), 64'(4'b0010));
    check("s4_rsp_data_b", 64'(rsp_data), 64'(pre7));

    // Reset right after a read is accepted: the response is dropped.
    set_req(1, 1'b0, 16'd0, '0);
    @(negedge clock);
    check("s5_ready", 64'(req_ready), 64'(4'b0010));
    reset_n = 1'b0;
    #1;
    check("s5_ready_rst", 64'(req_ready), 64'(0));
    check("s5_en1_rst", 64'(mem_en1), 64'(0));
    check("s5_rsp_valid_rst", 64'(rsp_valid), 64'(0));
    @(posedge clock);
    #1;
    check("s5_rsp_valid_next", 64'(rsp_valid), 64'(0));
    check("s5_en2_next", 64'(mem_en2), 64'(0));
    clear_reqs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Hazard: write 7 then the read of 7 waits; pointer restarts at 0.
    set_req(0, 1'b1, 16'd7, DATA'(36'h11));
    set_req(1, 1'b0, 16'd7, '0);
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    check("s3_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    check("s3_rsp_data", 64'(rsp_data), 64'(36'h11));
`ifdef BRAM_ARB_STATS_EN
    check("s6_grants", 64'(stat_grants), 64'(2));
    check("s6_conflicts", 64'(stat_conflicts), 64'(1));
`endif

    // Randomized traffic; requests hold until accepted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom_range(1, 0) == 1))
          set_req(i, ($urandom_range(1, 0) == 1), pool[$urandom_range(NPOOL-1, 0)],
                  DATA'({$urandom(), $urandom()}));
      end
      step('0, 1'b0);
    end
    clear_reqs();
    step('0, 1'b0);
    step('0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
